product_display_driver: RTL and testbench
=========================================

PRODUCT_DISPLAY_DRIVER -- requirements
Module: product_display_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_CNT_W, default 10, giving the refresh counter width; the digit toggles every 2^REFRESH_CNT_W cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_product, input, 6 bits: unsigned product from the multiplier core, range 0..63.
REQ-005 The block SHALL have port i_valid, input, 1 bit: i_product is valid this cycle.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts i_product this cycle.
REQ-007 The block SHALL have port o_segments, output, 7 bits: {g,f,e,d,c,b,a}, active-high, registered.
REQ-008 The block SHALL have port o_lsb_digit, output, 1 bit, registered: 1 = units digit shown, 0 = tens digit shown.

Function
REQ-009 The FSM SHALL have three states: IDLE (no value loaded), CONVERT (binary-to-BCD in progress) and DISPLAY (value loaded).
REQ-010 o_ready SHALL be 1 in IDLE and DISPLAY and 0 in CONVERT.
REQ-011 Accept SHALL be i_valid&o_ready at edge N: the block captures i_product and moves to CONVERT.
REQ-012 CONVERT SHALL run a shift-add-3 (double-dabble) conversion, one input bit per cycle, MSB first, for exactly 6 cycles.
REQ-013 Before each shift, the conversion SHALL add 3 to any BCD nibble that is >= 5.
REQ-014 Tens and units BCD nibbles SHALL each be 4 bits; tens is 0..6 and units is 0..9.
REQ-015 At edge N+6 the tens and units display registers SHALL update atomically and the FSM SHALL enter DISPLAY.
REQ-016 o_segments SHALL reflect the new value from edge N+7 onward.
REQ-017 During CONVERT, o_segments SHALL keep showing the previously displayed value, or blank if leaving IDLE.
REQ-018 i_valid while o_ready=0 SHALL be ignored: no capture and no queuing.
REQ-019 A refresh counter of REFRESH_CNT_W bits SHALL run free in all states.
REQ-020 On refresh counter wrap (all-ones to 0), the digit-select register SHALL toggle.
REQ-021 o_segments and o_lsb_digit SHALL follow digit-select with one cycle of register latency.
REQ-022 Segment codes SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex).
REQ-023 Leading-zero suppression: when the tens digit is 0 and is selected, o_segments SHALL be 00.
REQ-024 In IDLE, o_segments SHALL be 00 for both digits, and o_lsb_digit SHALL still toggle.
REQ-025 A refresh wrap coinciding with a display-register update SHALL apply both; the new digit is shown with the new value.
REQ-026 An accept in DISPLAY SHALL restart conversion; the old value is held until edge N+6.

Reset
REQ-027 reset_n low SHALL asynchronously force: FSM=IDLE, o_ready=1, BCD and display registers=0, refresh counter=0, digit-select=units, o_segments=00, o_lsb_digit=1.
REQ-028 Reset asserted mid-CONVERT SHALL abort the conversion; no partial value ever reaches the display registers.
REQ-029 After reset_n deasserts, the first accept SHALL be possible on the next rising edge.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the ten segment-code constants, the blank code 00, and the conversion step count 6.
REQ-031 The BCD-to-7-segment lookup SHALL be a combinational sub-module, seg7_decoder (4-bit in, 7-bit out, 00 for codes 10..15), instantiated once after the digit mux.
REQ-032 All other logic (FSM, double-dabble datapath, refresh counter, output registers) SHALL reside in product_display_driver.

Verification
REQ-033 Bench SHALL check reset: reset_n low mid-run -> immediately o_segments=00, o_lsb_digit=1, o_ready=1.
REQ-034 Bench SHALL check load 42 (REFRESH_CNT_W=2): accept at N -> o_ready=0 for N+1..N+6; from N+7 units phase shows 5B with o_lsb_digit=1, tens phase shows 66 with o_lsb_digit=0, toggling every 4 cycles.
REQ-035 Bench SHALL check load 0 then 49: 0 -> units 3F, tens 00 (suppressed); 49 -> units 6F, tens 66; 63 -> units 4F, tens 7D.
REQ-036 Bench SHALL check busy rejection: accept 12, then i_valid with 35 at N+3 -> ignored; display settles to 12 (units 5B, tens 06).
REQ-037 Bench SHALL check reload: in DISPLAY showing 21, accept 8 -> 21 held through N+6; from N+7 units 7F, tens 00.
REQ-038 Bench SHALL check reset mid-CONVERT: accept 27, reset_n low at N+3 -> IDLE, blank; no 27 digits ever appear after release.

Source files
------------

// File: rtl/product_display_driver_pkg.sv
// Shared types and constants for the product display driver: FSM states,
// seven-segment codes and the double-dabble step count.
package product_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int CONV_STEPS = 6;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/product_display_driver_seg7.sv
// Combinational BCD to seven-segment lookup ({g,f,e,d,c,b,a}, active-high);
// non-decimal codes render blank.
module seg7_decoder
    import product_display_driver_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/product_display_driver.sv
// Two-digit multiplexed display of a 6-bit product: serial double-dabble
// conversion followed by a free-running digit refresh.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | nothing loaded yet, both digits blank
// ST_CONVERT | double-dabble running, one input bit per cycle
// ST_DISPLAY | tens/units registers hold a converted value
module product_display_driver
    import product_display_driver_pkg::*;
#(
    parameter int REFRESH_CNT_W = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] i_product,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [6:0] o_segments,
    output logic       o_lsb_digit
);

    state_t                   r_state;
    logic [5:0]               r_bin;
    logic [7:0]               r_bcd;
    logic [2:0]               r_step;
    logic [3:0]               r_tens;
    logic [3:0]               r_units;
    logic                     r_loaded;
    logic [REFRESH_CNT_W-1:0] r_refresh;
    logic                     r_sel;

    logic       w_accept;
    logic [3:0] w_units_adj;
    logic [2:0] w_tens_lo;
    logic [7:0] w_bcd_shift;
    logic [3:0] w_digit;
    logic [6:0] w_seg_dec;
    logic       w_blank;

    assign o_ready  = (r_state != ST_CONVERT);
    assign w_accept = i_valid && o_ready;

    // Tens never exceeds 6, so only its low three bits survive the shift.
    assign w_units_adj = add3(r_bcd[3:0]);
    assign w_tens_lo   = r_bcd[6:4] + ((r_bcd[7:4] >= 4'd5) ? 3'd3 : 3'd0);
    assign w_bcd_shift = {w_tens_lo, w_units_adj, r_bin[5]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_step   <= '0;
            r_tens   <= '0;
            r_units  <= '0;
            r_loaded <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DISPLAY: begin
                    if (w_accept) begin
                        r_bin   <= i_product;
                        r_bcd   <= '0;
                        r_step  <= '0;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    r_bcd  <= w_bcd_shift;
                    r_bin  <= {r_bin[4:0], 1'b0};
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'(CONV_STEPS - 1)) begin
                        r_tens   <= w_bcd_shift[7:4];
                        r_units  <= w_bcd_shift[3:0];
                        r_loaded <= 1'b1;
                        r_state  <= ST_DISPLAY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_digit = r_sel ? r_units : r_tens;
    assign w_blank = !r_loaded || (!r_sel && (r_tens == 4'd0));

    seg7_decoder u_seg7 (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_refresh   <= '0;
            r_sel       <= 1'b1;
            o_segments  <= SEG_BLANK;
            o_lsb_digit <= 1'b1;
        end else begin
            r_refresh <= r_refresh + REFRESH_CNT_W'(1);
            if (&r_refresh)
                r_sel <= ~r_sel;
            o_segments  <= w_blank ? SEG_BLANK : w_seg_dec;
            o_lsb_digit <= r_sel;
        end
    end

endmodule

// File: tb/tb_product_display_driver.sv
// Directed bench for product_display_driver with a 2-bit refresh counter;
// digit phase is predicted from the number of clock edges since reset.
module tb_product_display_driver;

    localparam int RW = 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] i_product = '0;
    logic       i_valid   = 1'b0;
    logic       o_ready;
    logic [6:0] o_segments;
    logic       o_lsb_digit;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt;

    always #5 clk = ~clk;

    product_display_driver #(.REFRESH_CNT_W(RW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_product   (i_product),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_segments  (o_segments),
        .o_lsb_digit (o_lsb_digit)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Digit select toggles on every 2^RW-th edge; outputs lag it by one edge.
    function automatic logic exp_lsb();
        if (edge_cnt == 0) return 1'b1;
        return (((edge_cnt - 1) / (1 << RW)) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk_disp(input string tag, input logic [6:0] u, input logic [6:0] t);
        logic e;
        e = exp_lsb();
        chk({tag, "_lsb"}, {31'b0, o_lsb_digit}, {31'b0, e});
        chk({tag, "_seg"}, {25'b0, o_segments}, {25'b0, (e ? u : t)});
    endtask

    task automatic watch(input string tag, input logic [6:0] u, input logic [6:0] t, input int n);
        repeat (n) begin
            @(negedge clk);
            chk_disp(tag, u, t);
        end
    endtask

    // Entered and left at a negedge; accept happens at the following posedge.
    task automatic do_load(input string tag, input logic [5:0] val,
                           input bit busy, input logic [5:0] busy_val,
                           input logic [6:0] old_u, input logic [6:0] old_t,
                           input logic [6:0] new_u, input logic [6:0] new_t);
        chk({tag, "_rdy_pre"}, {31'b0, o_ready}, 32'd1);
        i_valid   = 1'b1;
        i_product = val;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            chk({tag, "_rdy"}, {31'b0, o_ready}, (k == 6) ? 32'd1 : 32'd0);
            chk_disp({tag, "_hold"}, old_u, old_t);
            if (busy && k == 2) begin
                i_valid   = 1'b1;
                i_product = busy_val;
            end
            if (k == 5) i_valid = 1'b0;
            @(negedge clk);
        end
        chk_disp({tag, "_new"}, new_u, new_t);
        watch({tag, "_run"}, new_u, new_t, 9);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_seg", {25'b0, o_segments}, 32'h00);
        chk("rst_lsb", {31'b0, o_lsb_digit}, 32'd1);
        chk("rst_rdy", {31'b0, o_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_load("l42", 6'd42, 1'b0, 6'd0,  7'h00, 7'h00, 7'h5B, 7'h66);
        do_load("l0",  6'd0,  1'b0, 6'd0,  7'h5B, 7'h66, 7'h3F, 7'h00);
        do_load("l49", 6'd49, 1'b0, 6'd0,  7'h3F, 7'h00, 7'h6F, 7'h66);
        do_load("l63", 6'd63, 1'b0, 6'd0,  7'h6F, 7'h66, 7'h4F, 7'h7D);
        do_load("l12", 6'd12, 1'b1, 6'd35, 7'h4F, 7'h7D, 7'h5B, 7'h06);
        do_load("l21", 6'd21, 1'b0, 6'd0,  7'h5B, 7'h06, 7'h06, 7'h5B);
        do_load("l8",  6'd8,  1'b0, 6'd0,  7'h06, 7'h5B, 7'h7F, 7'h00);

        chk("l27_rdy_pre", {31'b0, o_ready}, 32'd1);
        i_valid   = 1'b1;
        i_product = 6'd27;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_seg", {25'b0, o_segments}, 32'h00);
        chk("mid_rst_lsb", {31'b0, o_lsb_digit}, 32'd1);
        chk("mid_rst_rdy", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        watch("idle", 7'h00, 7'h00, 24);
        chk("idle_rdy", {31'b0, o_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
